thor2024_fetchbuf: RTL and testbench
====================================

# thor2024_fetchbuf

Dual-output instruction fetch buffer sitting between the instruction-cache fetch port and the issue-queue enqueue/tail-pointer logic. Accepts up to two instructions per cycle from fetch and presents the two oldest buffered instructions as fetchbuf0/fetchbuf1. Retires 0, 1 or 2 of them per cycle according to the enqueue count returned by the queue, and flushes completely on a branch miss.

## Interface
- FB_DEPTH, 4, buffer slots (power of two, ≥2)
- INSN_W, 40, instruction width in bits
- PC_W, 32, program-counter width
- INSN_BYTES, 5, byte size of one instruction (PC increment)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- branchmiss  in  1  flush all buffered instructions
- ic_v  in  1  fetch word valid (slot 0 present)
- ic_v1  in  1  second instruction valid (ignored unless ic_v)
- ic_pc  in  PC_W  PC of fetch slot 0; slot 1 PC = ic_pc + INSN_BYTES (mod 2^PC_W)
- ic_instr0, ic_instr1  in  INSN_W  fetched instructions
- ic_rdy  out  1  buffer can accept two instructions this cycle
- deq_cnt  in  2  instructions taken by enqueue this cycle (0..2)
- fetchbuf0_v, fetchbuf1_v  out  1  output slot valid
- fetchbuf0_instr, fetchbuf1_instr  out  INSN_W  oldest / second-oldest instruction
- fetchbuf0_pc, fetchbuf1_pc  out  PC_W  matching PCs

## Operation
- Circular storage of FB_DEPTH {pc, instr} entries; rd_ptr, wr_ptr (log2 FB_DEPTH bits, natural wrap), count (0..FB_DEPTH).
- Outputs: fetchbuf0 = entry[rd_ptr] when count≥1; fetchbuf1 = entry[rd_ptr+1] when count≥2. Invalid slots drive v=0, instr=0, pc=0.
- ic_rdy = (count ≤ FB_DEPTH-2); registered-state function only, never depends on deq_cnt or ic_v.
- Write: when ic_v & ic_rdy & ~branchmiss, write slot 0 at wr_ptr, slot 1 at wr_ptr+1 if ic_v1; nwr = 1 + ic_v1.
- Dequeue: eff_deq = min(deq_cnt, number of valid outputs); deq_cnt=3 treated as 2. rd_ptr += eff_deq.
- Next count = count + nwr − eff_deq; simultaneous write and dequeue legal in the same cycle.
- ic_v while ic_rdy=0: data dropped; fetch must hold and retry.
- branchmiss: rd_ptr, wr_ptr, count ← 0 next cycle; same-cycle ic_v data and deq_cnt ignored. Outputs still show pre-flush contents during the branchmiss cycle.
- Assertions (sim only): deq_cnt > valid outputs; ic_v1 without ic_v.

## Timing
- Reset (async assert): count=0, rd_ptr=wr_ptr=0, all fetchbuf outputs 0, ic_rdy=1; storage contents need not be cleared.
- Reset released mid-operation: all buffered data lost; first accept possible on first clock after deassertion.
- Latency without bypass: instruction accepted on edge N is visible on fetchbuf0/1 after edge N, i.e. in cycle N+1.
- Full: count=FB_DEPTH-1 or FB_DEPTH → ic_rdy=0; count=FB_DEPTH-2 still accepts two.
- Empty: count=0 → both outputs invalid; deq_cnt forced to 0 effect.
- Wrap: pointers wrap at FB_DEPTH; a two-slot write or dequeue straddling the wrap is legal.

## Configuration
- THOR_FB_BYPASS_EN defined: when count<2 and ic_v & ic_rdy, incoming instructions fill empty output slots combinationally in the same cycle (visible order: stored entries, then ic slot 0, then ic slot 1). deq_cnt consumes from this combined view; only the unconsumed incoming instructions are written. ic_rdy is unchanged (still registered-count based, no combinational loop). Zero-cycle latency when empty. Bypass suppressed while branchmiss=1.
- Not defined: no bypass; outputs depend only on registered storage; 1-cycle fetch-to-output latency.

## Test plan
- Reset/fill: after rst, ic_v=1, ic_v1=1, ic_pc=0x100, deq_cnt=0 → next cycle fetchbuf0_pc=0x100, fetchbuf1_pc=0x105, both v=1, count=2, ic_rdy=1.
- Full stall: fill to count=4 with deq_cnt=0 → ic_rdy=0; ic_v pulse with ic_pc=0x200 dropped; deq_cnt=2 → count=2, ic_rdy=1 next cycle, 0x200 never appears.
- Simultaneous: count=2, ic_v=1, ic_v1=0, deq_cnt=1 → count=2, fetchbuf0 = old second entry, fetchbuf1 = new instruction.
- Wrap: 6 consecutive single-instruction writes each dequeued with deq_cnt=1 (PCs 0x0,0x5,…,0x19) → output PC order strictly sequential across pointer wrap, no gaps.
- Flush: count=3, branchmiss=1 with ic_v=1 → next cycle both v=0, count=0; following ic_v with ic_pc=0x400 appears normally.
- Bypass (THOR_FB_BYPASS_EN): empty, ic_v=1, ic_v1=1, ic_pc=0x300, deq_cnt=1 same cycle → fetchbuf0_pc=0x300 valid that cycle; next cycle fetchbuf0_pc=0x305, count=1. Without macro: fetchbuf0_v=0 that cycle.

Source files
------------

// File: rtl/thor2024_fetchbuf.sv
// ============================================================================
// thor2024_fetchbuf : dual-output instruction fetch buffer (circular, 2-in/2-out)
// Optional macro THOR_FB_BYPASS_EN: same-cycle bypass of fetch into empty slots.
// Rev 1.0
// ============================================================================
`default_nettype none

module thor2024_fetchbuf #(
  parameter int FB_DEPTH   = 4,
  parameter int INSN_W     = 40,
  parameter int PC_W       = 32,
  parameter int INSN_BYTES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branchmiss,
  input  logic              ic_v,
  input  logic              ic_v1,
  input  logic [PC_W-1:0]   ic_pc,
  input  logic [INSN_W-1:0] ic_instr0,
  input  logic [INSN_W-1:0] ic_instr1,
  output logic              ic_rdy,
  input  logic [1:0]        deq_cnt,
  output logic              fetchbuf0_v,
  output logic              fetchbuf1_v,
  output logic [INSN_W-1:0] fetchbuf0_instr,
  output logic [INSN_W-1:0] fetchbuf1_instr,
  output logic [PC_W-1:0]   fetchbuf0_pc,
  output logic [PC_W-1:0]   fetchbuf1_pc
);

  localparam int PTR_W = $clog2(FB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(FB_DEPTH - 2);

  logic [PC_W-1:0]   mem_pc    [FB_DEPTH];
  logic [INSN_W-1:0] mem_instr [FB_DEPTH];

  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0]  w_rd_ptr1, w_wr_ptr1;
  logic [PC_W-1:0]   w_in1_pc;
  logic              w_wr_en, w_bypass;
  logic [1:0]        w_in_n, w_stored_vis, w_avail, w_deq_req, w_eff;
  logic [1:0]        w_st_cons, w_in_cons, w_nwr;
  logic [2:0]        w_tot;
  logic [PC_W-1:0]   w_wr0_pc, w_wr1_pc;
  logic [INSN_W-1:0] w_wr0_instr, w_wr1_instr;

  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_in1_pc  = ic_pc + PC_W'(INSN_BYTES);

  assign ic_rdy  = (r_count <= RDY_MAX);
  assign w_wr_en = ic_v && ic_rdy && !branchmiss;
  assign w_in_n  = w_wr_en ? (ic_v1 ? 2'd2 : 2'd1) : 2'd0;

`ifdef THOR_FB_BYPASS_EN
  assign w_bypass = w_wr_en && (r_count < CNT_W'(2));
`else
  assign w_bypass = 1'b0;
`endif

  // Combined view: stored entries first, then bypassed incoming ones.
  assign w_stored_vis = (r_count >= CNT_W'(2)) ? 2'd2 : r_count[1:0];
  assign w_tot        = {1'b0, w_stored_vis} + (w_bypass ? {1'b0, w_in_n} : 3'd0);
  assign w_avail      = (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
  assign w_deq_req    = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
  assign w_eff        = (w_deq_req < w_avail) ? w_deq_req : w_avail;
  assign w_st_cons    = (w_eff < w_stored_vis) ? w_eff : w_stored_vis;
  assign w_in_cons    = w_eff - w_st_cons;

  always_comb begin
    fetchbuf0_v     = 1'b0;
    fetchbuf0_pc    = '0;
    fetchbuf0_instr = '0;
    fetchbuf1_v     = 1'b0;
    fetchbuf1_pc    = '0;
    fetchbuf1_instr = '0;
    if (w_stored_vis != 2'd0) begin
      fetchbuf0_v     = 1'b1;
      fetchbuf0_pc    = mem_pc[r_rd_ptr];
      fetchbuf0_instr = mem_instr[r_rd_ptr];
    end else if (w_bypass) begin
      fetchbuf0_v     = 1'b1;
      fetchbuf0_pc    = ic_pc;
      fetchbuf0_instr = ic_instr0;
    end
    if (w_stored_vis == 2'd2) begin
      fetchbuf1_v     = 1'b1;
      fetchbuf1_pc    = mem_pc[w_rd_ptr1];
      fetchbuf1_instr = mem_instr[w_rd_ptr1];
    end else if (w_bypass && w_stored_vis == 2'd1) begin
      fetchbuf1_v     = 1'b1;
      fetchbuf1_pc    = ic_pc;
      fetchbuf1_instr = ic_instr0;
    end else if (w_bypass && ic_v1) begin
      fetchbuf1_v     = 1'b1;
      fetchbuf1_pc    = w_in1_pc;
      fetchbuf1_instr = ic_instr1;
    end
  end

  // Only incoming instructions not already consumed through the bypass are stored.
  always_comb begin
    w_wr0_pc    = ic_pc;
    w_wr0_instr = ic_instr0;
    w_wr1_pc    = w_in1_pc;
    w_wr1_instr = ic_instr1;
    w_nwr       = w_in_n;
    if (w_in_cons == 2'd1) begin
      w_wr0_pc    = w_in1_pc;
      w_wr0_instr = ic_instr1;
      w_nwr       = w_in_n - 2'd1;
    end else if (w_in_cons == 2'd2) begin
      w_nwr       = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !branchmiss) begin
      if (w_nwr != 2'd0) begin
        mem_pc[r_wr_ptr]    <= w_wr0_pc;
        mem_instr[r_wr_ptr] <= w_wr0_instr;
      end
      if (w_nwr == 2'd2) begin
        mem_pc[w_wr_ptr1]    <= w_wr1_pc;
        mem_instr[w_wr_ptr1] <= w_wr1_instr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (branchmiss) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_st_cons);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_nwr);
      r_count  <= r_count + CNT_W'(w_nwr) - CNT_W'(w_st_cons);
    end
  end

`ifndef SYNTHESIS
  a_deq_overrun: assert property (@(posedge clk) disable iff (rst)
    branchmiss || (deq_cnt <= w_avail));
  a_v1_without_v: assert property (@(posedge clk) disable iff (rst)
    !(ic_v1 && !ic_v));
`endif

endmodule

`default_nettype wire

// File: tb/tb_thor2024_fetchbuf.sv
// ============================================================================
// tb_thor2024_fetchbuf : directed self-checking bench for thor2024_fetchbuf
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_thor2024_fetchbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branchmiss;
  logic        ic_v, ic_v1;
  logic [31:0] ic_pc;
  logic [39:0] ic_instr0, ic_instr1;
  logic        ic_rdy;
  logic [1:0]  deq_cnt;
  logic        fetchbuf0_v, fetchbuf1_v;
  logic [39:0] fetchbuf0_instr, fetchbuf1_instr;
  logic [31:0] fetchbuf0_pc, fetchbuf1_pc;

  int n_checks = 0;
  int n_fail   = 0;

  thor2024_fetchbuf #(.FB_DEPTH(4), .INSN_W(40), .PC_W(32), .INSN_BYTES(5)) dut (
    .clk(clk), .rst(rst), .branchmiss(branchmiss),
    .ic_v(ic_v), .ic_v1(ic_v1), .ic_pc(ic_pc),
    .ic_instr0(ic_instr0), .ic_instr1(ic_instr1), .ic_rdy(ic_rdy),
    .deq_cnt(deq_cnt),
    .fetchbuf0_v(fetchbuf0_v), .fetchbuf1_v(fetchbuf1_v),
    .fetchbuf0_instr(fetchbuf0_instr), .fetchbuf1_instr(fetchbuf1_instr),
    .fetchbuf0_pc(fetchbuf0_pc), .fetchbuf1_pc(fetchbuf1_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction encoding derives from its PC so pc/instr pairing is checkable.
  task automatic drive(input logic v, input logic v1, input logic [31:0] pc,
                       input logic [1:0] d, input logic bm);
    ic_v       = v;
    ic_v1      = v1;
    ic_pc      = pc;
    ic_instr0  = {8'hA5, pc};
    ic_instr1  = {8'hA5, pc + 32'd5};
    deq_cnt    = d;
    branchmiss = bm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_fb0_v", fetchbuf0_v, 0);
    chk("rst_fb1_v", fetchbuf1_v, 0);
    chk("rst_fb0_pc", fetchbuf0_pc, 0);
    chk("rst_fb0_instr", fetchbuf0_instr, 0);
    chk("rst_ic_rdy", ic_rdy, 1);
    tick(); tick();
    rst = 1'b0;

    // Fill two
    drive(1, 1, 32'h100, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("fill_fb0_v", fetchbuf0_v, 1);
    chk("fill_fb0_pc", fetchbuf0_pc, 32'h100);
    chk("fill_fb0_instr", fetchbuf0_instr, 40'hA5_0000_0100);
    chk("fill_fb1_v", fetchbuf1_v, 1);
    chk("fill_fb1_pc", fetchbuf1_pc, 32'h105);
    chk("fill_fb1_instr", fetchbuf1_instr, 40'hA5_0000_0105);
    chk("fill_ic_rdy", ic_rdy, 1);

    // Full stall
    drive(1, 1, 32'h10A, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("full_ic_rdy", ic_rdy, 0);
    chk("full_fb0_pc", fetchbuf0_pc, 32'h100);
    drive(1, 0, 32'h200, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("drop_ic_rdy", ic_rdy, 0);
    drive(0, 0, 0, 2, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("deq2_ic_rdy", ic_rdy, 1);
    chk("deq2_fb0_pc", fetchbuf0_pc, 32'h10A);
    chk("deq2_fb1_pc", fetchbuf1_pc, 32'h10F);
    drive(0, 0, 0, 2, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("drained_fb0_v", fetchbuf0_v, 0);
    chk("drained_fb1_v", fetchbuf1_v, 0);

    // Simultaneous write and dequeue
    drive(1, 1, 32'h110, 0, 0); tick();
    drive(1, 0, 32'h11A, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("simul_fb0_pc", fetchbuf0_pc, 32'h115);
    chk("simul_fb1_v", fetchbuf1_v, 1);
    chk("simul_fb1_pc", fetchbuf1_pc, 32'h11A);
    chk("simul_ic_rdy", ic_rdy, 1);
    drive(0, 0, 0, 2, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("simul_empty", fetchbuf0_v, 0);

    // Wrap: pointers start at 3 here
    drive(1, 0, 32'h0, 0, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      chk("wrap_fb0_v", fetchbuf0_v, 1);
      chk("wrap_fb0_pc", fetchbuf0_pc, 32'(5 * (i - 1)));
      chk("wrap_fb1_v", fetchbuf1_v, 0);
      drive(1, 0, 32'(5 * i), 1, 0); tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("wrap_last_pc", fetchbuf0_pc, 32'h19);
    chk("wrap_last_instr", fetchbuf0_instr, 40'hA5_0000_0019);
    drive(0, 0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("wrap_empty", fetchbuf0_v, 0);

    // Flush with count=3
    drive(1, 1, 32'h120, 0, 0); tick();
    drive(1, 0, 32'h12A, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("c3_fb0_pc", fetchbuf0_pc, 32'h120);
    chk("c3_fb1_pc", fetchbuf1_pc, 32'h125);
    chk("c3_ic_rdy", ic_rdy, 0);
    drive(1, 1, 32'h500, 0, 1); #1;
    chk("bm_cycle_fb0_v", fetchbuf0_v, 1);
    chk("bm_cycle_fb0_pc", fetchbuf0_pc, 32'h120);
    tick(); drive(0, 0, 0, 0, 0);
    chk("flush_fb0_v", fetchbuf0_v, 0);
    chk("flush_fb1_v", fetchbuf1_v, 0);
    chk("flush_ic_rdy", ic_rdy, 1);
    drive(1, 0, 32'h400, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("post_flush_fb0_v", fetchbuf0_v, 1);
    chk("post_flush_fb0_pc", fetchbuf0_pc, 32'h400);
    chk("post_flush_fb1_v", fetchbuf1_v, 0);
    drive(0, 0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("pre_byp_empty", fetchbuf0_v, 0);

    // Same-cycle view when empty
`ifdef THOR_FB_BYPASS_EN
    drive(1, 1, 32'h300, 1, 0); #1;
    chk("byp_fb0_v", fetchbuf0_v, 1);
    chk("byp_fb0_pc", fetchbuf0_pc, 32'h300);
    chk("byp_fb1_pc", fetchbuf1_pc, 32'h305);
    tick(); drive(0, 0, 0, 0, 0);
    chk("byp_next_fb0_pc", fetchbuf0_pc, 32'h305);
    chk("byp_next_fb1_v", fetchbuf1_v, 0);
`else
    drive(1, 1, 32'h300, 0, 0); #1;
    chk("nobyp_fb0_v", fetchbuf0_v, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("nobyp_next_fb0_pc", fetchbuf0_pc, 32'h300);
    chk("nobyp_next_fb1_pc", fetchbuf1_pc, 32'h305);
`endif

    // Asynchronous reset mid-operation, then PC wrap on slot 1
    #3 rst = 1'b1;
    #1;
    chk("arst_fb0_v", fetchbuf0_v, 0);
    chk("arst_fb0_pc", fetchbuf0_pc, 0);
    chk("arst_ic_rdy", ic_rdy, 1);
    tick();
    rst = 1'b0;
    drive(1, 1, 32'hFFFF_FFFE, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("pcwrap_fb0_pc", fetchbuf0_pc, 32'hFFFF_FFFE);
    chk("pcwrap_fb1_pc", fetchbuf1_pc, 32'h3);
    chk("pcwrap_fb1_instr", fetchbuf1_instr, 40'hA5_0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
